// File: rtl/opti_frame_ctrl.sv
// Frame controller for the cascaded-SOS IIR datapath: gates sample acceptance and pipeline
// advance, registers final-stage results under ready/valid backpressure, and tracks frames.
module opti_frame_ctrl #(
   parameter int DATA_W    = 24,
   parameter int FRAME_LEN = 2048,
   parameter int ADDR_W    = 11,
   parameter int SETTLE_N  = 8,
   parameter int TIMEOUT   = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              mode_cont,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              sos_out_valid,
   input  logic [DATA_W-1:0] sos_out_data,
   input  logic              out_ready,
   output logic              pipeline_en,
   output logic [DATA_W-1:0] data_out,
   output logic              data_out_valid,
   output logic [ADDR_W-1:0] addr,
   output logic              stable_out,
   output logic              filter_done,
   output logic [15:0]       frame_cnt,
   output logic              timeout_err
);

   typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

   localparam int              WD_W     = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W:0] LEN      = (ADDR_W + 1)'(FRAME_LEN);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

   state_t          state, state_next;
   logic [ADDR_W:0] in_cnt, out_cnt;
   logic [WD_W-1:0] wd_cnt, wd_inc;
   logic            load, accept, stall, wd_expire, frame_end;

   // The pipeline only advances when the output register can take whatever emerges this cycle.
   always_comb begin
      pipeline_en = (state == RUN) && (!data_out_valid || out_ready);
      in_ready    = pipeline_en && (in_cnt < LEN);
      filter_done = (state == DONE);
      load        = sos_out_valid && pipeline_en && (out_cnt < LEN);
      accept      = in_valid && in_ready;
      stall       = pipeline_en && (in_cnt > out_cnt) && !sos_out_valid;
      wd_inc      = wd_cnt + 1'b1;
      wd_expire   = stall && (wd_inc == WD_LIMIT);
      frame_end   = (state == RUN) && (out_cnt == LEN) && !data_out_valid;
   end

   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_next = RUN;
            RUN: begin
               if (wd_expire)      state_next = ERR;
               else if (frame_end) state_next = DONE;
            end
            DONE:    state_next = mode_cont ? RUN : IDLE;
            default: state_next = ERR;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Abort clears everything except frame_cnt, which survives until the next start from IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_cnt         <= '0;
         out_cnt        <= '0;
         wd_cnt         <= '0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         addr           <= '0;
         stable_out     <= 1'b0;
         frame_cnt      <= '0;
         timeout_err    <= 1'b0;
      end else if (abort) begin
         in_cnt         <= '0;
         out_cnt        <= '0;
         wd_cnt         <= '0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         addr           <= '0;
         stable_out     <= 1'b0;
         timeout_err    <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            frame_cnt  <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            stable_out <= 1'b0;
         end
         if (state == DONE) begin
            in_cnt     <= '0;
            out_cnt    <= '0;
            stable_out <= 1'b0;
         end
         if (accept) in_cnt <= in_cnt + 1'b1;
         if (load) begin
            data_out       <= sos_out_data;
            addr           <= out_cnt[ADDR_W-1:0];
            out_cnt        <= out_cnt + 1'b1;
            data_out_valid <= 1'b1;
            if (int'(out_cnt) + 1 >= SETTLE_N) stable_out <= 1'b1;
         end else if (out_ready) begin
            data_out_valid <= 1'b0;
         end
         // Only stalls with the pipeline free to move count; backpressure holds never do.
         if (state != RUN || sos_out_valid) wd_cnt <= '0;
         else if (stall)                    wd_cnt <= wd_inc;
         if (wd_expire) begin
            timeout_err <= 1'b1;
            wd_cnt      <= '0;
         end
         if (frame_end) frame_cnt <= frame_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_opti_frame_ctrl.sv
// Randomized bench for opti_frame_ctrl: a latency-5 SOS stand-in, a cycle-level behavioural
// model checked every negedge, a result scoreboard, and literal checks for the directed scenarios.
module tb_opti_frame_ctrl;

   localparam int DW = 24;
   localparam int FL = 16;
   localparam int AW = 4;
   localparam int SN = 4;
   localparam int TO = 8;

   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_DONE = 2;
   localparam int S_ERR  = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          mode_cont = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic          in_ready, sos_out_valid, pipeline_en, data_out_valid;
   logic          stable_out, filter_done, timeout_err;
   logic [DW-1:0] sos_out_data, data_out;
   logic [AW-1:0] addr;
   logic [15:0]   frame_cnt;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int or_mode = 0;
   bit force_iv = 1'b0;

   always #5 clk = ~clk;

   opti_frame_ctrl #(
      .DATA_W(DW), .FRAME_LEN(FL), .ADDR_W(AW), .SETTLE_N(SN), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mode_cont(mode_cont),
      .in_valid(in_valid), .in_ready(in_ready), .sos_out_valid(sos_out_valid),
      .sos_out_data(sos_out_data), .out_ready(out_ready), .pipeline_en(pipeline_en),
      .data_out(data_out), .data_out_valid(data_out_valid), .addr(addr),
      .stable_out(stable_out), .filter_done(filter_done), .frame_cnt(frame_cnt),
      .timeout_err(timeout_err)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // SOS stand-in: 5-stage shift register advancing with pipeline_en, random sample values.
   logic          pv [5];
   logic [DW-1:0] pd [5];
   int            sos_emitted = 0;
   int            sos_limit = 1 << 30;

   assign sos_out_valid = pv[4] && pipeline_en && (sos_emitted < sos_limit);
   assign sos_out_data  = pd[4];

   always @(posedge clk or posedge rst) begin
      if (rst || abort) begin
         for (int i = 0; i < 5; i++) begin
            pv[i] <= 1'b0;
            pd[i] <= '0;
         end
      end else if (pipeline_en) begin
         if (sos_out_valid) sos_emitted <= sos_emitted + 1;
         for (int i = 4; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
         end
         pv[0] <= in_valid && in_ready;
         pd[0] <= DW'($urandom);
      end
   end

   // Behavioural model state and result scoreboard.
   int            m_state, m_in, m_out, m_wd, m_frames, m_addr;
   bit            m_dv, m_stable, m_terr;
   logic [DW-1:0] m_data;
   logic [DW-1:0] sb_q [$];
   int            frame_idx = 0;
   int            xfer_total = 0;
   int            done_pulses = 0;

   always @(negedge clk) begin
      bit e_pen, e_inr, load, stall, done_now, acc;
      logic [DW-1:0] front;
      if (rst) begin
         m_state = S_IDLE; m_in = 0; m_out = 0; m_wd = 0; m_frames = 0; m_addr = 0;
         m_dv = 0; m_stable = 0; m_terr = 0; m_data = '0;
         sb_q.delete();
         frame_idx = 0;
         checkOutput("reset_in_ready", in_ready, 0);
         checkOutput("reset_pipeline_en", pipeline_en, 0);
         checkOutput("reset_data_out_valid", data_out_valid, 0);
         checkOutput("reset_data_out", data_out, 0);
         checkOutput("reset_addr", addr, 0);
         checkOutput("reset_stable_out", stable_out, 0);
         checkOutput("reset_filter_done", filter_done, 0);
         checkOutput("reset_frame_cnt", frame_cnt, 0);
         checkOutput("reset_timeout_err", timeout_err, 0);
      end else begin
         e_pen = (m_state == S_RUN) && (!m_dv || out_ready);
         e_inr = e_pen && (m_in < FL);
         checkOutput("pipeline_en", pipeline_en, e_pen);
         checkOutput("in_ready", in_ready, e_inr);
         checkOutput("data_out_valid", data_out_valid, m_dv);
         checkOutput("stable_out", stable_out, m_stable);
         checkOutput("filter_done", filter_done, m_state == S_DONE);
         checkOutput("frame_cnt", frame_cnt, m_frames);
         checkOutput("timeout_err", timeout_err, m_terr);
         if (m_dv) begin
            checkOutput("data_out", data_out, m_data);
            checkOutput("addr", addr, m_addr);
         end

         // Every handed-off result must be the next SOS output, numbered within its frame.
         if (data_out_valid && out_ready) begin
            checkOutput("sb_has_result", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
               front = sb_q.pop_front();
               checkOutput("sb_data", data_out, front);
            end
            checkOutput("sb_addr", addr, frame_idx);
            frame_idx++;
            xfer_total++;
         end
         if (filter_done) begin
            done_pulses++;
            frame_idx = 0;
         end
         if (abort) begin
            sb_q.delete();
            frame_idx = 0;
         end else if (sos_out_valid) begin
            sb_q.push_back(sos_out_data);
         end

         acc = in_valid && e_inr;
         if (abort) begin
            m_state = S_IDLE; m_in = 0; m_out = 0; m_wd = 0;
            m_dv = 0; m_stable = 0; m_terr = 0;
         end else begin
            case (m_state)
               S_IDLE: begin
                  if (start) begin
                     m_state = S_RUN; m_frames = 0; m_in = 0; m_out = 0; m_stable = 0;
                  end
               end
               S_RUN: begin
                  load     = sos_out_valid && e_pen && (m_out < FL);
                  stall    = e_pen && (m_in > m_out) && !sos_out_valid;
                  done_now = (m_out == FL) && !m_dv;
                  if (sos_out_valid) m_wd = 0;
                  else if (stall)    m_wd = m_wd + 1;
                  if (m_dv && out_ready) m_dv = 0;
                  if (load) begin
                     m_dv = 1; m_data = sos_out_data; m_addr = m_out; m_out = m_out + 1;
                     if (m_out >= SN) m_stable = 1;
                  end
                  if (acc) m_in = m_in + 1;
                  if (m_wd == TO) begin
                     m_state = S_ERR; m_terr = 1; m_wd = 0;
                  end else if (done_now) begin
                     m_state = S_DONE; m_frames = (m_frames + 1) % 65536; m_wd = 0;
                  end
               end
               S_DONE: begin
                  m_in = 0; m_out = 0; m_stable = 0;
                  m_state = mode_cont ? S_RUN : S_IDLE;
               end
               default: begin
                  if (m_dv && out_ready) m_dv = 0;
               end
            endcase
         end
      end
   end

   // One clock of stimulus: pulses drop, in_valid/out_ready are re-drawn per mode.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      in_valid = force_iv ? 1'b1 : ($urandom_range(0, 3) != 0);
      case (or_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic waitDone(input int target, input int budget);
      for (int k = 0; k < budget && done_pulses < target; k++) applyStimulus();
      checkOutput("wait_done", done_pulses, target);
   endtask

   initial begin
      int  b_done, b_x, t5;
      bit  prev_st, seen_rise;

      repeat (3) applyStimulus();
      rst = 1'b0;
      applyStimulus();
      checkOutput("idle_pipeline_en", pipeline_en, 0);

      $display("[TB] single-shot frame, out_ready high");
      or_mode = 0; mode_cont = 1'b0;
      b_done = done_pulses; b_x = xfer_total;
      start = 1'b1;
      prev_st = 1'b0; seen_rise = 1'b0;
      for (int k = 0; k < 400 && done_pulses == b_done; k++) begin
         applyStimulus();
         if (stable_out && !prev_st) begin
            checkOutput("stable_rise_addr", addr, 3);
            checkOutput("stable_rise_valid", data_out_valid, 1);
            seen_rise = 1'b1;
         end
         prev_st = stable_out;
      end
      repeat (3) applyStimulus();
      checkOutput("t1_done_pulses", done_pulses - b_done, 1);
      checkOutput("t1_results", xfer_total - b_x, 16);
      checkOutput("t1_frame_cnt", frame_cnt, 1);
      checkOutput("t1_stable_seen", seen_rise, 1);
      checkOutput("t1_idle_in_ready", in_ready, 0);

      $display("[TB] single-shot frame, out_ready toggling");
      or_mode = 1;
      b_done = done_pulses; b_x = xfer_total;
      start = 1'b1;
      waitDone(b_done + 1, 600);
      repeat (3) applyStimulus();
      checkOutput("t2_results", xfer_total - b_x, 16);
      checkOutput("t2_frame_cnt", frame_cnt, 1);

      $display("[TB] continuous frames, random backpressure");
      or_mode = 2; mode_cont = 1'b1;
      b_done = done_pulses; b_x = xfer_total;
      start = 1'b1;
      waitDone(b_done + 2, 800);
      mode_cont = 1'b0;
      waitDone(b_done + 3, 400);
      repeat (4) applyStimulus();
      checkOutput("t3_done_pulses", done_pulses - b_done, 3);
      checkOutput("t3_frame_cnt", frame_cnt, 3);
      checkOutput("t3_results", xfer_total - b_x, 48);
      checkOutput("t3_idle_pipeline_en", pipeline_en, 0);

      $display("[TB] watchdog");
      or_mode = 0; force_iv = 1'b1;
      sos_limit = sos_emitted + 5;
      t5 = -100;
      start = 1'b1;
      for (int k = 0; k < 200 && !timeout_err; k++) begin
         applyStimulus();
         if (data_out_valid && addr == 4 && t5 < 0) t5 = cyc;
      end
      checkOutput("timeout_err_set", timeout_err, 1);
      checkOutput("timeout_latency", cyc - t5, 8);
      start = 1'b1;
      repeat (3) applyStimulus();
      checkOutput("err_ignores_start", timeout_err, 1);
      checkOutput("err_pipeline_en", pipeline_en, 0);
      abort = 1'b1;
      applyStimulus();
      checkOutput("abort_clears_err", timeout_err, 0);
      sos_limit = 1 << 30; force_iv = 1'b0;

      $display("[TB] abort mid-frame");
      start = 1'b1;
      for (int k = 0; k < 300 && !(data_out_valid && addr == 7); k++) applyStimulus();
      checkOutput("abort_point_addr", addr, 7);
      abort = 1'b1;
      applyStimulus();
      checkOutput("abort_data_out_valid", data_out_valid, 0);
      checkOutput("abort_in_ready", in_ready, 0);
      b_done = done_pulses;
      start = 1'b1;
      for (int k = 0; k < 100 && !data_out_valid; k++) applyStimulus();
      checkOutput("restart_addr", addr, 0);
      checkOutput("restart_frame_cnt", frame_cnt, 0);
      waitDone(b_done + 1, 300);
      applyStimulus();
      checkOutput("restart_frame_done_cnt", frame_cnt, 1);

      $display("[TB] asynchronous reset mid-run");
      or_mode = 2;
      start = 1'b1;
      for (int k = 0; k < 300 && !(data_out_valid && addr >= 5); k++) applyStimulus();
      #2 rst = 1'b1;
      #1;
      checkOutput("arst_data_out_valid", data_out_valid, 0);
      checkOutput("arst_pipeline_en", pipeline_en, 0);
      checkOutput("arst_in_ready", in_ready, 0);
      checkOutput("arst_stable_out", stable_out, 0);
      checkOutput("arst_frame_cnt", frame_cnt, 0);
      checkOutput("arst_addr", addr, 0);
      b_done = done_pulses;
      repeat (3) applyStimulus();
      rst = 1'b0;
      repeat (4) applyStimulus();
      checkOutput("arst_no_done", done_pulses - b_done, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_time_limit: got expired, expected completion");
      $fatal(1, "[TB] time limit");
   end

endmodule
